// File: rtl/regfile_mp_pkg.sv
// Shared constants, the address-width helper and the busy-vector type for regfile_mp.
package regfile_pkg;

  localparam int unsigned NREGS_DEF   = 32;
  localparam int unsigned SP_IDX_DEF  = 2;
  localparam logic [31:0] SP_INIT_DEF = 32'h7fff_fffc;

  // Busy vector for the default register count; parametrised modules size their own.
  typedef logic [NREGS_DEF-1:0] busy_vec_t;

  function automatic int unsigned aw_f(input int unsigned nregs);
    return unsigned'($clog2(nregs));
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and issue/scoreboard bundle of the multi-port register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1
);
  localparam int unsigned AW = aw_f(NREGS);

  logic [NRD-1:0][AW-1:0]     rd_addr_i;
  logic [NRD-1:0][DWIDTH-1:0] rd_data_o;
  logic [NRD-1:0]             rd_busy_o;
  logic [NWR-1:0]             wr_en_i;
  logic [NWR-1:0][AW-1:0]     wr_addr_i;
  logic [NWR-1:0][DWIDTH-1:0] wr_data_i;
  logic                       iss_valid_i;
  logic [AW-1:0]              iss_rd_i;
  logic                       flush_i;
  logic [AW:0]                busy_cnt_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_valid_i, iss_rd_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_cnt_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_valid_i, iss_rd_i, flush_i,
    output rd_data_o, rd_busy_o, busy_cnt_o
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Busy scoreboard: one bit per register with flush > issue > writeback priority,
// plus a registered popcount of the post-edge busy vector.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = aw_f(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid_i,
  input  logic [AW-1:0]    iss_rd_i,
  input  logic             flush_i,
  input  logic [NREGS-1:0] wr_vec_i,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      busy_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  // A new producer supersedes a writeback to the same register in the same cycle.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (iss_valid_i && (iss_rd_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_vec_i[r]) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Counting busy_d keeps the count aligned with the bits it describes.
  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 1,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned SP_IDX  = SP_IDX_DEF,
  parameter logic [31:0] SP_INIT = SP_INIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned AW = aw_f(NREGS);
  localparam logic [DWIDTH-1:0] SP_RST = DWIDTH'(SP_INIT);

  logic [DWIDTH-1:0]          regs_q [NREGS];
  logic [DWIDTH-1:0]          regs_d [NREGS];
  logic [NREGS-1:0]           wr_vec;
  logic [NREGS-1:0]           busy_vec;
  logic [NRD-1:0][DWIDTH-1:0] rd_data;
  logic [NRD-1:0]             rd_busy;

  // Ports are visited in ascending order so the highest-numbered port wins a collision.
  always_comb begin
    regs_d = regs_q;
    wr_vec = '0;
    for (int p = 0; p < NWR; p++) begin
      if (bus.wr_en_i[p] && (bus.wr_addr_i[p] != '0)) begin
        regs_d[bus.wr_addr_i[p]] = bus.wr_data_i[p];
        wr_vec[bus.wr_addr_i[p]] = 1'b1;
      end
    end
    regs_d[0] = '0;
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst) begin
        regs_q[gi] <= ((gi == SP_IDX) && (gi != 0)) ? SP_RST : '0;
      end else begin
        regs_q[gi] <= regs_d[gi];
      end
    end
  end

  always_comb begin
    for (int rp = 0; rp < NRD; rp++) begin
      rd_data[rp] = regs_q[bus.rd_addr_i[rp]];
      if ((BYPASS != 0) && (bus.rd_addr_i[rp] != '0)) begin
        for (int p = 0; p < NWR; p++) begin
          if (bus.wr_en_i[p] && (bus.wr_addr_i[p] == bus.rd_addr_i[rp])) begin
            rd_data[rp] = bus.wr_data_i[p];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_busy
    assign rd_busy[gi] = busy_vec[bus.rd_addr_i[gi]];
  end

  assign bus.rd_data_o = rd_data;
  assign bus.rd_busy_o = rd_busy;

  reg_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (bus.iss_valid_i),
    .iss_rd_i    (bus.iss_rd_i),
    .flush_i     (bus.flush_i),
    .wr_vec_i    (wr_vec),
    .busy_o      (busy_vec),
    .busy_cnt_o  (bus.busy_cnt_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a bypassing and a non-bypassing regfile_mp (NWR=2) share stimulus and one reference model.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk;
  logic rst;

  regfile_mp_if #(.DWIDTH(32), .NREGS(32), .NRD(2), .NWR(2)) if_b1 ();
  regfile_mp_if #(.DWIDTH(32), .NREGS(32), .NRD(2), .NWR(2)) if_b0 ();

  assign if_b0.rd_addr_i   = if_b1.rd_addr_i;
  assign if_b0.wr_en_i     = if_b1.wr_en_i;
  assign if_b0.wr_addr_i   = if_b1.wr_addr_i;
  assign if_b0.wr_data_i   = if_b1.wr_data_i;
  assign if_b0.iss_valid_i = if_b1.iss_valid_i;
  assign if_b0.iss_rd_i    = if_b1.iss_rd_i;
  assign if_b0.flush_i     = if_b1.flush_i;

  regfile_mp #(.DWIDTH(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1),
               .SP_IDX(2), .SP_INIT(32'h7fff_fffc))
    u_byp (.clk(clk), .rst(rst), .bus(if_b1));

  regfile_mp #(.DWIDTH(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0),
               .SP_IDX(2), .SP_INIT(32'h7fff_fffc))
    u_nobyp (.clk(clk), .rst(rst), .bus(if_b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mdl_reg [32];
  busy_vec_t   mdl_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    if_b1.wr_en_i     = '0;
    if_b1.wr_addr_i   = '0;
    if_b1.wr_data_i   = '0;
    if_b1.iss_valid_i = 1'b0;
    if_b1.iss_rd_i    = '0;
    if_b1.flush_i     = 1'b0;
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    if_b1.wr_en_i[port]   = 1'b1;
    if_b1.wr_addr_i[port] = 5'(addr);
    if_b1.wr_data_i[port] = data;
  endtask

  task automatic issue(input int addr);
    if_b1.iss_valid_i = 1'b1;
    if_b1.iss_rd_i    = 5'(addr);
  endtask

  // Reference reads: stored value, or for the bypassing copy the last enabled writer of that address.
  task automatic check_comb();
    logic [31:0] exp_b, exp_nb;
    int a;
    for (int rp = 0; rp < 2; rp++) begin
      a      = int'(if_b1.rd_addr_i[rp]);
      exp_nb = mdl_reg[a];
      exp_b  = exp_nb;
      if (a != 0) begin
        for (int w = 0; w < 2; w++) begin
          if (if_b1.wr_en_i[w] && int'(if_b1.wr_addr_i[w]) == a) exp_b = if_b1.wr_data_i[w];
        end
      end
      chk($sformatf("rd_byp[%0d] x%0d", rp, a), 64'(if_b1.rd_data_o[rp]), 64'(exp_b));
      chk($sformatf("rd_nobyp[%0d] x%0d", rp, a), 64'(if_b0.rd_data_o[rp]), 64'(exp_nb));
      chk($sformatf("busy_byp[%0d] x%0d", rp, a), 64'(if_b1.rd_busy_o[rp]), 64'(mdl_busy[a]));
      chk($sformatf("busy_nobyp[%0d] x%0d", rp, a), 64'(if_b0.rd_busy_o[rp]), 64'(mdl_busy[a]));
    end
    chk("busy_cnt_byp", 64'(if_b1.busy_cnt_o), 64'($countones(mdl_busy)));
    chk("busy_cnt_nobyp", 64'(if_b0.busy_cnt_o), 64'($countones(mdl_busy)));
  endtask

  // Edge behaviour as sequential rules: writes in port order, then writebacks clear, then issue sets.
  task automatic model_update();
    int a;
    if (!rst) begin
      for (int r = 0; r < 32; r++) mdl_reg[r] = 32'h0;
      mdl_reg[2] = 32'h7fff_fffc;
      mdl_busy   = '0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        a = int'(if_b1.wr_addr_i[w]);
        if (if_b1.wr_en_i[w] && a != 0) begin
          mdl_reg[a]  = if_b1.wr_data_i[w];
          mdl_busy[a] = 1'b0;
        end
      end
      if (if_b1.iss_valid_i && if_b1.iss_rd_i != 0) mdl_busy[if_b1.iss_rd_i] = 1'b1;
      if (if_b1.flush_i) mdl_busy = '0;
    end
  endtask

  task automatic tick();
    #1;
    check_comb();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_b1.rd_addr_i = '0;
    set_idle();
    for (int r = 0; r < 32; r++) mdl_reg[r] = 32'h0;
    mdl_busy = '0;

    // Reset for one edge; outputs are unknown before it, so no comparisons yet.
    rst = 1'b0;
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 16; k++) begin
      if_b1.rd_addr_i[0] = 5'(2 * k);
      if_b1.rd_addr_i[1] = 5'(2 * k + 1);
      tick();
    end
    if_b1.rd_addr_i[0] = 5'd2;
    if_b1.rd_addr_i[1] = 5'd3;
    #1;
    chk("sp_reset", 64'(if_b1.rd_data_o[0]), 64'h7fff_fffc);
    chk("x3_reset", 64'(if_b1.rd_data_o[1]), 64'h0);
    chk("cnt_reset", 64'(if_b1.busy_cnt_o), 64'h0);
    tick();

    // Writes to x0 are dropped and never bypassed.
    if_b1.rd_addr_i = '0;
    wr(0, 0, 32'hDEAD);
    #1;
    chk("x0_write_same", 64'(if_b1.rd_data_o[0]), 64'h0);
    tick();
    set_idle();
    #1;
    chk("x0_write_next", 64'(if_b1.rd_data_o[0]), 64'h0);
    tick();

    // Bypass versus stored-only read of x5.
    if_b1.rd_addr_i[0] = 5'd5;
    wr(0, 5, 32'h1234);
    #1;
    chk("bypass_same", 64'(if_b1.rd_data_o[0]), 64'h1234);
    chk("nobypass_same", 64'(if_b0.rd_data_o[0]), 64'h0);
    tick();
    set_idle();
    #1;
    chk("bypass_next", 64'(if_b1.rd_data_o[0]), 64'h1234);
    chk("nobypass_next", 64'(if_b0.rd_data_o[0]), 64'h1234);
    tick();

    // Write-write collision on x7: port 1 wins.
    if_b1.rd_addr_i[1] = 5'd7;
    wr(0, 7, 32'hAAAA);
    wr(1, 7, 32'hBBBB);
    #1;
    chk("collide_bypass", 64'(if_b1.rd_data_o[1]), 64'hBBBB);
    tick();
    set_idle();
    #1;
    chk("collide_stored", 64'(if_b0.rd_data_o[1]), 64'hBBBB);
    tick();

    // Scoreboard on x9.
    if_b1.rd_addr_i[0] = 5'd9;
    issue(9);
    tick();
    set_idle();
    #1;
    chk("sb_issue_busy", 64'(if_b1.rd_busy_o[0]), 64'h1);
    chk("sb_issue_cnt", 64'(if_b1.busy_cnt_o), 64'h1);
    wr(1, 9, 32'h99);
    tick();
    set_idle();
    #1;
    chk("sb_wb_busy", 64'(if_b1.rd_busy_o[0]), 64'h0);
    chk("sb_wb_cnt", 64'(if_b1.busy_cnt_o), 64'h0);
    issue(9);
    wr(0, 9, 32'h98);
    tick();
    set_idle();
    #1;
    chk("sb_iss_wb_busy", 64'(if_b1.rd_busy_o[0]), 64'h1);
    tick();

    // Flush wins over a same-cycle issue.
    issue(3); tick();
    issue(4); tick();
    issue(6); tick();
    set_idle();
    #1;
    chk("pre_flush_cnt", 64'(if_b1.busy_cnt_o), 64'h4);
    if_b1.flush_i = 1'b1;
    issue(8);
    tick();
    set_idle();
    if_b1.rd_addr_i[0] = 5'd8;
    if_b1.rd_addr_i[1] = 5'd3;
    #1;
    chk("flush_cnt", 64'(if_b1.busy_cnt_o), 64'h0);
    chk("flush_x8", 64'(if_b1.rd_busy_o[0]), 64'h0);
    chk("flush_x3", 64'(if_b1.rd_busy_o[1]), 64'h0);
    tick();

    // Reset discards a same-cycle write and issue.
    wr(0, 10, 32'h77);
    issue(11);
    tick();
    set_idle();
    rst = 1'b0;
    wr(0, 10, 32'h55);
    issue(11);
    tick();
    rst = 1'b1;
    set_idle();
    if_b1.rd_addr_i[0] = 5'd10;
    if_b1.rd_addr_i[1] = 5'd11;
    #1;
    chk("midrst_x10", 64'(if_b0.rd_data_o[0]), 64'h0);
    chk("midrst_x11_busy", 64'(if_b1.rd_busy_o[1]), 64'h0);
    chk("midrst_cnt", 64'(if_b1.busy_cnt_o), 64'h0);
    tick();

    // Randomised traffic with addresses biased toward a small window to provoke collisions.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) != 0);
      for (int w = 0; w < 2; w++) begin
        if_b1.wr_en_i[w]   = 1'($urandom_range(0, 1));
        if_b1.wr_addr_i[w] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        if_b1.wr_data_i[w] = $urandom;
      end
      if_b1.iss_valid_i = 1'($urandom_range(0, 1));
      if_b1.iss_rd_i    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      if_b1.flush_i     = ($urandom_range(0, 15) == 0);
      for (int rp = 0; rp < 2; rp++) begin
        if_b1.rd_addr_i[rp] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
